// File: rtl/decode_stage.sv
// RV32I decode stage: registered decode of one instruction per handshake into a
// two-entry output buffer, with synchronous flush on redirect.
`timescale 1ns/1ps
module decode_stage #(
  parameter int XLEN          = 32,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9:0]      out_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_ALUREG = 7'b0110011;
  localparam logic [6:0] OPC_ALUIMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [9:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     immI;
  logic [31:0]     immS;
  logic [31:0]     immB;
  logic [31:0]     immJ;
  logic [31:0]     immU;
  logic [9:0]      opDec;
  logic [31:0]     imm32;
  logic            illegalDec;
  logic [XLEN-1:0] immExt;
  entry_t          decoded;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign immI = {{20{in_instr[31]}}, in_instr[31:20]};
  assign immS = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign immB = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
  assign immJ = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
  assign immU = {in_instr[31:12], 12'b0};

  always_comb begin
    opDec      = '0;
    imm32      = '0;
    illegalDec = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      illegalDec = 1'b1;
    end else begin
      case (opcode)
        OPC_ALUREG: begin
          opDec[0] = 1'b1;
          if (CHECK_ILLEGAL &&
              !((funct7 == F7_ZERO) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
            illegalDec = 1'b1;
        end
        OPC_ALUIMM: begin
          opDec[1] = 1'b1;
          imm32    = immI;
          if (CHECK_ILLEGAL &&
              (((funct3 == 3'b001) && (funct7 != F7_ZERO)) ||
               ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT))))
            illegalDec = 1'b1;
        end
        OPC_BRANCH: begin
          opDec[2] = 1'b1;
          imm32    = immB;
          if (CHECK_ILLEGAL && ((funct3 == 3'b010) || (funct3 == 3'b011)))
            illegalDec = 1'b1;
        end
        OPC_JALR: begin
          opDec[3] = 1'b1;
          imm32    = immI;
          if (CHECK_ILLEGAL && (funct3 != 3'b000))
            illegalDec = 1'b1;
        end
        OPC_JAL: begin
          opDec[4] = 1'b1;
          imm32    = immJ;
        end
        OPC_AUIPC: begin
          opDec[5] = 1'b1;
          imm32    = immU;
        end
        OPC_LUI: begin
          opDec[6] = 1'b1;
          imm32    = immU;
        end
        OPC_LOAD: begin
          opDec[7] = 1'b1;
          imm32    = immI;
          if (CHECK_ILLEGAL &&
              ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)))
            illegalDec = 1'b1;
        end
        OPC_STORE: begin
          opDec[8] = 1'b1;
          imm32    = immS;
          if (CHECK_ILLEGAL && (funct3 >= 3'b011))
            illegalDec = 1'b1;
        end
        OPC_SYSTEM: begin
          opDec[9] = 1'b1;
          imm32    = immI;
        end
        default: illegalDec = 1'b1;
      endcase
    end
    // Illegal words keep their register/funct fields so execute can trap on them.
    if (illegalDec) begin
      opDec = '0;
      imm32 = '0;
    end
  end

  assign immExt = XLEN'($signed(imm32));

  always_comb begin
    decoded         = '0;
    decoded.op      = opDec;
    decoded.rs1     = in_instr[19:15];
    decoded.rs2     = in_instr[24:20];
    decoded.rd      = in_instr[11:7];
    decoded.funct3  = funct3;
    decoded.funct7  = funct7;
    decoded.imm     = immExt;
    decoded.pc      = in_pc;
    decoded.illegal = illegalDec;
  end

  buf_state_e stateQ, stateD;
  entry_t     headQ, headD;
  entry_t     tailQ, tailD;
  logic       inReadyQ, inReadyD;
  logic       push;
  logic       pop;

  assign push = in_valid & inReadyQ;
  assign pop  = (stateQ != EMPTY) & out_ready;

  // Flush wins over any handshake; the word presented in the flush cycle is dropped.
  always_comb begin
    stateD = stateQ;
    headD  = headQ;
    tailD  = tailQ;
    if (flush) begin
      stateD = EMPTY;
    end else begin
      case (stateQ)
        EMPTY: begin
          if (push) begin
            headD  = decoded;
            stateD = ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tailD  = decoded;
            stateD = TWO;
          end else if (push && pop) begin
            headD  = decoded;
          end else if (pop) begin
            stateD = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            headD  = tailQ;
            stateD = ONE;
          end
        end
        default: stateD = EMPTY;
      endcase
    end
    inReadyD = (stateD != TWO);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ   <= EMPTY;
      headQ    <= '0;
      tailQ    <= '0;
      inReadyQ <= 1'b1;
    end else begin
      stateQ   <= stateD;
      headQ    <= headD;
      tailQ    <= tailD;
      inReadyQ <= inReadyD;
    end
  end

  assign in_ready    = inReadyQ;
  assign out_valid   = (stateQ != EMPTY);
  assign out_op      = headQ.op;
  assign out_rs1     = headQ.rs1;
  assign out_rs2     = headQ.rs2;
  assign out_rd      = headQ.rd;
  assign out_funct3  = headQ.funct3;
  assign out_funct7  = headQ.funct7;
  assign out_imm     = headQ.imm;
  assign out_pc      = headQ.pc;
  assign out_illegal = headQ.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit fully checked instance and a 64-bit
// instance with the relaxed illegal check, both driven by the same inputs.
`timescale 1ns/1ps
module tb_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
    logic [9:0]  opB;
    logic [63:0] immB;
    logic        illB;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        inValid;
  logic [31:0] inInstr;
  logic [31:0] inPc;
  logic        outReady;

  logic        inReadyA, outValidA, illA;
  logic [9:0]  opA;
  logic [4:0]  rs1A, rs2A, rdA;
  logic [2:0]  f3A;
  logic [6:0]  f7A;
  logic [31:0] immA, pcA;

  logic        inReadyB, outValidB, illB;
  logic [9:0]  opB;
  logic [4:0]  rs1B, rs2B, rdB;
  logic [2:0]  f3B;
  logic [6:0]  f7B;
  logic [63:0] immB, pcB;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[17];

  decode_stage #(.XLEN(32), .CHECK_ILLEGAL(1'b1)) dutA (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyA), .in_instr(inInstr), .in_pc(inPc),
    .out_valid(outValidA), .out_ready(outReady), .out_op(opA),
    .out_rs1(rs1A), .out_rs2(rs2A), .out_rd(rdA),
    .out_funct3(f3A), .out_funct7(f7A), .out_imm(immA), .out_pc(pcA),
    .out_illegal(illA)
  );

  decode_stage #(.XLEN(64), .CHECK_ILLEGAL(1'b0)) dutB (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyB), .in_instr(inInstr), .in_pc({32'b0, inPc}),
    .out_valid(outValidB), .out_ready(outReady), .out_op(opB),
    .out_rs1(rs1B), .out_rs2(rs2B), .out_rd(rdB),
    .out_funct3(f3B), .out_funct7(f7B), .out_imm(immB), .out_pc(pcB),
    .out_illegal(illB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one word for exactly one rising edge, returning at the following falling edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    inValid = 1'b1;
    inInstr = instr;
    inPc    = pc;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] model[$];
    int          sent;
    int          popped;
    logic        pushNow;
    logic        popNow;

    //            instr          op      rd     rs1    rs2    f3    f7     imm           ill   opB     immB                    illB
    vecs[0]  = '{32'h00500093, 10'h002, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 1'b0, 10'h002, 64'h0000000000000005, 1'b0};
    vecs[1]  = '{32'hFFF00093, 10'h002, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 10'h002, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 10'h004, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 10'h004, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h008000EF, 10'h010, 5'd1,  5'd0,  5'd8,  3'd0, 7'h00, 32'h00000008, 1'b0, 10'h010, 64'h0000000000000008, 1'b0};
    vecs[4]  = '{32'h123452B7, 10'h040, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0, 10'h040, 64'h0000000012345000, 1'b0};
    vecs[5]  = '{32'h40001033, 10'h000, 5'd0,  5'd0,  5'd0,  3'd1, 7'h20, 32'h00000000, 1'b1, 10'h001, 64'h0000000000000000, 1'b0};
    vecs[6]  = '{32'h0000007F, 10'h000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1, 10'h000, 64'h0000000000000000, 1'b1};
    vecs[7]  = '{32'h00112423, 10'h100, 5'd8,  5'd2,  5'd1,  3'd2, 7'h00, 32'h00000008, 1'b0, 10'h100, 64'h0000000000000008, 1'b0};
    vecs[8]  = '{32'h00113423, 10'h000, 5'd8,  5'd2,  5'd1,  3'd3, 7'h00, 32'h00000000, 1'b1, 10'h100, 64'h0000000000000008, 1'b0};
    vecs[9]  = '{32'hFFFFF117, 10'h020, 5'd2,  5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFF000, 1'b0, 10'h020, 64'hFFFFFFFFFFFFF000, 1'b0};
    vecs[10] = '{32'hFFC12083, 10'h080, 5'd1,  5'd2,  5'd28, 3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0, 10'h080, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[11] = '{32'h000080E7, 10'h008, 5'd1,  5'd1,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b0, 10'h008, 64'h0000000000000000, 1'b0};
    vecs[12] = '{32'h000090E7, 10'h000, 5'd1,  5'd1,  5'd0,  3'd1, 7'h00, 32'h00000000, 1'b1, 10'h008, 64'h0000000000000000, 1'b0};
    vecs[13] = '{32'h00000073, 10'h200, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b0, 10'h200, 64'h0000000000000000, 1'b0};
    vecs[14] = '{32'h4010D093, 10'h002, 5'd1,  5'd1,  5'd1,  3'd5, 7'h20, 32'h00000401, 1'b0, 10'h002, 64'h0000000000000401, 1'b0};
    vecs[15] = '{32'h00500091, 10'h000, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000000, 1'b1, 10'h000, 64'h0000000000000000, 1'b1};
    vecs[16] = '{32'h00002063, 10'h000, 5'd0,  5'd0,  5'd0,  3'd2, 7'h00, 32'h00000000, 1'b1, 10'h004, 64'h0000000000000000, 1'b0};

    resetn   = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    inInstr  = '0;
    inPc     = '0;
    outReady = 1'b1;

    #12;
    checkOutput("reset valid", 64'(outValidA), 64'd0);
    checkOutput("reset ready", 64'(inReadyA), 64'd1);
    checkOutput("reset op", 64'(opA), 64'd0);
    checkOutput("reset rd", 64'(rdA), 64'd0);
    checkOutput("reset imm", 64'(immA), 64'd0);
    checkOutput("reset pc", 64'(pcA), 64'd0);
    checkOutput("reset illegal", 64'(illA), 64'd0);
    checkOutput("reset immB", immB, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].instr, 32'h1000 + 32'(i * 4));
      checkOutput($sformatf("v%0d valid", i), 64'(outValidA), 64'd1);
      checkOutput($sformatf("v%0d op", i), 64'(opA), 64'(vecs[i].op));
      checkOutput($sformatf("v%0d rd", i), 64'(rdA), 64'(vecs[i].rd));
      checkOutput($sformatf("v%0d rs1", i), 64'(rs1A), 64'(vecs[i].rs1));
      checkOutput($sformatf("v%0d rs2", i), 64'(rs2A), 64'(vecs[i].rs2));
      checkOutput($sformatf("v%0d funct3", i), 64'(f3A), 64'(vecs[i].f3));
      checkOutput($sformatf("v%0d funct7", i), 64'(f7A), 64'(vecs[i].f7));
      checkOutput($sformatf("v%0d imm", i), 64'(immA), 64'(vecs[i].imm));
      checkOutput($sformatf("v%0d pc", i), 64'(pcA), 64'h1000 + 64'(i * 4));
      checkOutput($sformatf("v%0d illegal", i), 64'(illA), 64'(vecs[i].ill));
      checkOutput($sformatf("v%0d opB", i), 64'(opB), 64'(vecs[i].opB));
      checkOutput($sformatf("v%0d immB", i), immB, vecs[i].immB);
      checkOutput($sformatf("v%0d illegalB", i), 64'(illB), 64'(vecs[i].illB));
      checkOutput($sformatf("v%0d pcB", i), pcB, 64'h1000 + 64'(i * 4));
    end

    // Streaming with a backpressure window, checked against a two-entry queue model.
    @(negedge clk);
    sent   = 0;
    popped = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      checkOutput($sformatf("stream c%0d valid", cyc), 64'(outValidA), 64'(model.size() != 0));
      checkOutput($sformatf("stream c%0d ready", cyc), 64'(inReadyA), 64'(model.size() != 2));
      if (model.size() != 0)
        checkOutput($sformatf("stream c%0d head", cyc), 64'(immA), 64'(model[0]));
      inValid  = (sent < 6);
      inInstr  = {12'(sent + 1), 20'h00013};
      inPc     = 32'h2000;
      outReady = !((cyc >= 2) && (cyc <= 5));
      pushNow  = inValid && (model.size() != 2);
      popNow   = (model.size() != 0) && outReady;
      @(posedge clk);
      if (popNow) begin
        void'(model.pop_front());
        popped++;
      end
      if (pushNow) begin
        model.push_back(32'(sent + 1));
        sent++;
      end
      @(negedge clk);
    end
    checkOutput("stream popped", 64'(popped), 64'd6);
    inValid  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);

    // Flush while holding two entries, with a word offered that must never appear.
    outReady = 1'b0;
    inValid  = 1'b1;
    inInstr  = 32'h01100013;
    @(negedge clk);
    inInstr  = 32'h02200013;
    @(negedge clk);
    checkOutput("full ready", 64'(inReadyA), 64'd0);
    checkOutput("full head", 64'(immA), 64'h11);
    flush    = 1'b1;
    inInstr  = 32'h03300013;
    @(negedge clk);
    flush    = 1'b0;
    inValid  = 1'b0;
    checkOutput("flush2 valid", 64'(outValidA), 64'd0);
    checkOutput("flush2 ready", 64'(inReadyA), 64'd1);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("flush2 quiet", 64'(outValidA), 64'd0);

    // Flush while one entry is held and the offered word would otherwise be accepted.
    outReady = 1'b0;
    inValid  = 1'b1;
    inInstr  = 32'h04400013;
    @(negedge clk);
    flush    = 1'b1;
    inInstr  = 32'h05500013;
    @(negedge clk);
    flush    = 1'b0;
    inValid  = 1'b0;
    checkOutput("flush1 valid", 64'(outValidA), 64'd0);
    checkOutput("flush1 ready", 64'(inReadyA), 64'd1);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("flush1 quiet", 64'(outValidA), 64'd0);

    // Asynchronous reset between clock edges while the buffer is full.
    outReady = 1'b0;
    inValid  = 1'b1;
    inInstr  = 32'h06600013;
    inPc     = 32'h3000;
    @(negedge clk);
    inInstr  = 32'h07700013;
    @(negedge clk);
    inValid  = 1'b0;
    checkOutput("prereset valid", 64'(outValidA), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async valid", 64'(outValidA), 64'd0);
    checkOutput("async ready", 64'(inReadyA), 64'd1);
    checkOutput("async op", 64'(opA), 64'd0);
    checkOutput("async imm", 64'(immA), 64'd0);
    checkOutput("async pc", 64'(pcA), 64'd0);
    checkOutput("async rd", 64'(rdA), 64'd0);
    checkOutput("async validB", 64'(outValidB), 64'd0);
    @(negedge clk);
    resetn   = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("postreset valid", 64'(outValidA), 64'd0);
    checkOutput("postreset imm", 64'(immA), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
